uart_tx_fifo_reader: RTL and testbench
======================================

Name: uart_tx_fifo_reader

Overview:
UART transmitter that drains a first-word-fall-through FIFO and serialises each byte onto the line as 8N1 (or 8N2), LSB first.
- Sits on the read side of the TX buffer FIFO: the FIFO's data/empty outputs connect to this block's inputs, and its rd_en input is driven by this block.
- Sustains back-to-back frames with zero idle gap while the FIFO is non-empty.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 115200, line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer-truncated, must be >= 2.
- DATA_WIDTH, 8, bits per frame payload.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd). Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  permits starting new frames; has no effect on a frame in progress.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  DATA_WIDTH  FWFT head word; valid whenever fifo_empty_i=0.
- fifo_rd_en_o  out  1  pop strobe; high exactly one cycle per consumed word.
- tx_o  out  1  serial line, idle high, registered.
- busy_o  out  1  high from the cycle after a pop through the last stop-bit cycle.
- tx_done_o  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset values: tx_o=1, busy_o=0, fifo_rd_en_o=0, tx_done_o=0; state IDLE; baud counter, bit index and shift register all 0.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Pop condition: pop = enable_i & !fifo_empty_i & (state==IDLE | last cycle of final stop bit).
  - fifo_rd_en_o = pop, combinational from state and inputs.
  - On pop: fifo_data_i is latched into the shift register and the next state is START.
- IDLE: tx_o=1; stays in IDLE until pop.
- START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_o=shift[0]; shift right every CLKS_PER_BIT cycles. After DATA_WIDTH bits go to PARITY if enabled, else STOP.
- STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, tx_done_o=1; then START if pop, else IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry; it does not free-run.
  - Width is $clog2(CLKS_PER_BIT). The bit index is $clog2(DATA_WIDTH)+1 bits wide.
- Frame length is exactly (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back frames: zero gap. The start bit follows the final stop-bit cycle directly.
- Latency: a pop in cycle N puts tx_o=0 at cycle N+1.
- Never pops when fifo_empty_i=1, even if enable_i=1. fifo_data_i is not sampled when empty.
- enable_i dropped mid-frame: the current frame completes and no further pop occurs.
- Reset mid-frame: next cycle tx_o=1 and state IDLE. The partially sent byte is lost and there is no pop in the reset cycle.
- busy_o is the registered equivalent of state!=IDLE. During back-to-back frames it stays high continuously.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx_o = ^data XOR PARITY_ODD, computed from the latched byte at pop time.
- Undefined:
  - No PARITY state, no parity register; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants UART_IDLE_LVL=1'b1, UART_START_LVL=1'b0.
  - Function clks_per_bit(clk_hz, baud).
- Sub-module uart_baud_cnt:
  - Inputs: clear, enable.
  - Output: bit_end strobe on count CLKS_PER_BIT-1.
  - Shared later with the receiver.

Test Plan:
All scenarios use CLK_FREQ_HZ=400, BAUD_RATE=100, so CLKS_PER_BIT=4, with STOP_BITS=1.
1. Reset held 3 cycles, fifo_empty_i=1 for 20 cycles -> tx_o=1, fifo_rd_en_o=0, busy_o=0 throughout.
2. Single word 0xA5, enable_i=1:
   - One-cycle fifo_rd_en_o.
   - tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
   - tx_done_o high at cycle 40 only.
3. FIFO holds 0x00 then 0xFF:
   - Pops exactly 40 cycles apart.
   - Second start bit immediately follows the first stop bit.
   - busy_o continuously high for 80 cycles.
4. enable_i=0 with FIFO non-empty -> no pop for 50 cycles. Then enable_i=1 and drop it after 10 cycles -> exactly one frame completes, no second pop.
5. rst_i asserted during data bit 3 of 0x5A -> tx_o=1 and busy_o=0 the next cycle; no tx_done_o; the next frame starts cleanly on the next non-empty FIFO.
6. With UART_TX_PARITY_EN and PARITY_ODD=0, send 0xA5 -> parity bit 0, frame is 44 cycles. Repeat with 0x07 -> parity bit 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, line levels and baud helper.
// Used by the TX FIFO reader and its baud counter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   // Integer-truncated clock cycles per line bit.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, strobes bit_end on the last count.
// Cleared explicitly by the owner on every state entry; shared with the receiver.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      end
   end

   assign bit_end = enable && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining a FWFT FIFO, 8N1/8N2 LSB first, back-to-back with no idle gap.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_tx_fifo_reader #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_WIDTH  = 8,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_ODD  = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_rd_en_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  tx_done_o
);

   import uart_pkg::*;

   localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int BW  = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   uart_tx_state_t        state, state_nxt;
   logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
   logic [BW-1:0]         idx_q, idx_nxt;
   logic                  tx_q, tx_nxt;
   logic                  busy_q;
   logic                  bit_end;
   logic                  final_stop;
   logic                  pop;
   logic                  par_nxt;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CPB)
   ) u_baud (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear  (state_nxt != state),
      .enable (state != IDLE),
      .bit_end(bit_end)
   );

`ifdef UART_TX_PARITY_EN
   logic par_q;

   // Parity is fixed at pop time from the latched word, not recomputed while shifting.
   assign par_nxt = pop ? ((^fifo_data_i) ^ (PARITY_ODD != 0)) : par_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) par_q <= 1'b0;
      else       par_q <= par_nxt;
   end
`else
   logic unused_parity_odd;

   assign par_nxt           = 1'b0;
   assign unused_parity_odd = (PARITY_ODD != 0) | par_nxt;
`endif

   assign final_stop = (state == STOP) && bit_end && (idx_q == STOP_LAST);
   // Reset gating keeps the reset cycle free of pops and done pulses.
   assign pop        = !rst_i && enable_i && !fifo_empty_i && ((state == IDLE) || final_stop);

   always_comb begin
      state_nxt = state;
      shift_nxt = shift_q;
      idx_nxt   = idx_q;
      case (state)
         IDLE: ;
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               idx_nxt   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
                  idx_nxt   = '0;
               end else begin
                  idx_nxt   = idx_q + 1'b1;
                  shift_nxt = shift_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               idx_nxt   = '0;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (idx_q == STOP_LAST) state_nxt = IDLE;
               else                    idx_nxt   = idx_q + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A pop overrides whatever the frame logic chose, giving the zero-gap restart.
      if (pop) begin
         state_nxt = START;
         shift_nxt = fifo_data_i;
         idx_nxt   = '0;
      end
   end

   // Line level is derived from the next state so tx_o is registered yet lands one cycle after the pop.
   always_comb begin
      tx_nxt = UART_IDLE_LVL;
      case (state_nxt)
         START:   tx_nxt = UART_START_LVL;
         DATA:    tx_nxt = shift_nxt[0];
         PARITY:  tx_nxt = par_nxt;
         default: tx_nxt = UART_IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= UART_IDLE_LVL;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shift_q <= shift_nxt;
         idx_q   <= idx_nxt;
         tx_q    <= tx_nxt;
         busy_q  <= (state_nxt != IDLE);
      end
   end

   assign fifo_rd_en_o = pop;
   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign tx_done_o    = final_stop && !rst_i;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Scoreboard bench for uart_tx_fifo_reader at 4 clocks per bit, 1 stop bit.
// Main thread issues words with hand-computed line frames; a negedge monitor decodes tx_o and compares.
module tb_uart_tx_fifo_reader;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FLEN = FBITS * CPB;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       enable_i;
   logic       fifo_empty_i;
   logic [7:0] fifo_data_i;
   logic       fifo_rd_en_o;
   logic       tx_o;
   logic       busy_o;
   logic       tx_done_o;

   uart_tx_fifo_reader #(
      .CLK_FREQ_HZ(400),
      .BAUD_RATE  (100),
      .DATA_WIDTH (8),
      .STOP_BITS  (1),
      .PARITY_ODD (0)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .fifo_empty_i(fifo_empty_i),
      .fifo_data_i (fifo_data_i),
      .fifo_rd_en_o(fifo_rd_en_o),
      .tx_o        (tx_o),
      .busy_o      (busy_o),
      .tx_done_o   (tx_done_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Stimulus mailbox into the FIFO model, plus expected frames.
   logic [7:0] stim_mem [0:63];
   int         stim_wr   = 0;
   int         flush_req = 0;
   int         exp_q [$];

   task automatic push(input logic [7:0] b, input int frame10, input bit par);
      stim_mem[stim_wr] = b;
      stim_wr++;
`ifdef UART_TX_PARITY_EN
      exp_q.push_back(32'h400 | (int'(par) << 9) | (frame10 & 'h1FF));
`else
      exp_q.push_back(frame10 + 0 * int'(par));
`endif
   endtask

   task automatic push_raw(input logic [7:0] b);
      stim_mem[stim_wr] = b;
      stim_wr++;
   endtask

   // FWFT FIFO model
   initial begin
      int  stim_rd;
      int  flush_seen;
      bit  do_pop;
      logic [7:0] fifo_q [$];
      stim_rd      = 0;
      flush_seen   = 0;
      fifo_empty_i = 1'b1;
      fifo_data_i  = 8'hEE;
      forever begin
         @(negedge clk_i);
         do_pop = fifo_rd_en_o;
         @(posedge clk_i);
         #1;
         if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
         if (flush_seen != flush_req) begin
            fifo_q.delete();
            flush_seen = flush_req;
         end
         while (stim_rd < stim_wr) begin
            fifo_q.push_back(stim_mem[stim_rd]);
            stim_rd++;
         end
         fifo_empty_i = (fifo_q.size() == 0);
         fifo_data_i  = fifo_empty_i ? 8'hEE : fifo_q[0];
      end
   end

   // Monitor: event log and frame decoder
   int cyc = 0;
   int pop_cnt = 0;
   int done_cnt = 0;
   int pop_cyc [$];
   int done_cyc [$];

   initial begin
      bit          in_frame;
      int          fcyc;
      int          bi;
      logic [15:0] cap;
      bit          glitch, busy_ok, done_bad;
      in_frame = 0;
      fcyc = 0; cap = '0; glitch = 0; busy_ok = 1; done_bad = 0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (rst_i) begin
            check("rst_cycle_quiet", int'({fifo_rd_en_o, tx_done_o}), 0);
            if (in_frame) begin
               in_frame = 0;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end else begin
            if (fifo_rd_en_o) begin
               pop_cnt++;
               pop_cyc.push_back(cyc);
            end
            if (tx_done_o) begin
               done_cnt++;
               done_cyc.push_back(cyc);
               if (!in_frame) check("done_outside_frame", 1, 0);
            end
            if (!in_frame && tx_o == 1'b0) begin
               in_frame = 1;
               fcyc = 0; cap = '0; glitch = 0; busy_ok = 1; done_bad = 0;
            end
            if (in_frame) begin
               bi = fcyc / CPB;
               if (fcyc % CPB == 0)     cap[bi] = tx_o;
               else if (cap[bi] != tx_o) glitch = 1;
               if (!busy_o) busy_ok = 0;
               if (tx_done_o != (fcyc == FLEN - 1)) done_bad = 1;
               fcyc++;
               if (fcyc == FLEN) begin
                  in_frame = 0;
                  if (exp_q.size() == 0) check("frame_unexpected", int'(cap), -1);
                  else                   check("frame_bits", int'(cap), exp_q.pop_front());
                  check("frame_bit_stable", int'(glitch), 0);
                  check("frame_busy", int'(busy_ok), 1);
                  check("frame_done_pos", int'(done_bad), 0);
               end
            end
         end
      end
   end

   task automatic negs(input int n);
      repeat (n) begin
         @(negedge clk_i);
         #1;
      end
   endtask

   task automatic wait_pop(input int target, input string nm);
      int k = 0;
      while (pop_cnt < target && k < 200) begin
         @(negedge clk_i);
         #1;
         k++;
      end
      check(nm, int'(pop_cnt >= target), 1);
   endtask

   task automatic wait_done(input int target, input string nm);
      int k = 0;
      while (done_cnt < target && k < 300) begin
         @(negedge clk_i);
         #1;
         k++;
      end
      check(nm, int'(done_cnt >= target), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, d0, n_bad;
      rst_i    = 1'b1;
      enable_i = 1'b1;

      // 1: reset, then empty FIFO with enable high
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      negs(1);
      check("t1_rst_tx", int'(tx_o), 1);
      check("t1_rst_busy", int'(busy_o), 0);
      check("t1_rst_rden", int'(fifo_rd_en_o), 0);
      check("t1_rst_done", int'(tx_done_o), 0);
      n_bad = 0;
      repeat (20) begin
         negs(1);
         if (tx_o !== 1'b1 || fifo_rd_en_o !== 1'b0 || busy_o !== 1'b0) n_bad++;
      end
      check("t1_idle_20cyc", n_bad, 0);
      check("t1_no_pop", pop_cnt, 0);

      // 2: single word 0xA5
      p0 = pop_cnt; d0 = done_cnt;
      push(8'hA5, 'h34A, 1'b0);
      wait_done(d0 + 1, "t2_done_seen");
      check("t2_pops", pop_cnt - p0, 1);
      check("t2_frame_len", done_cyc[d0] - pop_cyc[p0], FLEN);
      negs(3);
      check("t2_after_tx", int'(tx_o), 1);
      check("t2_after_busy", int'(busy_o), 0);

      // 3: back-to-back 0x00 then 0xFF
      negs(2);
      p0 = pop_cnt; d0 = done_cnt;
      push(8'h00, 'h200, 1'b0);
      push(8'hFF, 'h3FE, 1'b0);
      wait_pop(p0 + 1, "t3_first_pop");
      n_bad = 0;
      repeat (2 * FLEN) begin
         negs(1);
         if (busy_o !== 1'b1) n_bad++;
      end
      check("t3_busy_continuous", n_bad, 0);
      negs(1);
      check("t3_busy_drops", int'(busy_o), 0);
      wait_done(d0 + 2, "t3_done_seen");
      check("t3_pops", pop_cnt - p0, 2);
      check("t3_pop_gap", pop_cyc[p0 + 1] - pop_cyc[p0], FLEN);
      check("t3_zero_gap", pop_cyc[p0 + 1] - done_cyc[d0], 0);

      // 4: enable low holds off, one frame after a brief enable
      negs(2);
      enable_i = 1'b0;
      p0 = pop_cnt; d0 = done_cnt;
      push(8'h3C, 'h278, 1'b0);
      push_raw(8'h81);
      negs(50);
      check("t4_no_pop_disabled", pop_cnt - p0, 0);
      @(posedge clk_i);
      #1;
      enable_i = 1'b1;
      repeat (10) @(posedge clk_i);
      #1;
      enable_i = 1'b0;
      wait_done(d0 + 1, "t4_done_seen");
      negs(60);
      check("t4_pops", pop_cnt - p0, 1);
      check("t4_dones", done_cnt - d0, 1);
      flush_req++;
      negs(3);

      // 5: reset during data bit 3 of 0x5A, then a clean frame
      enable_i = 1'b1;
      p0 = pop_cnt; d0 = done_cnt;
      push(8'h5A, 'h2B4, 1'b0);
      wait_pop(p0 + 1, "t5_pop");
      repeat (18) @(posedge clk_i);
      #1;
      check("t5_bit3_level", int'(tx_o), 1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("t5_rst_tx", int'(tx_o), 1);
      check("t5_rst_busy", int'(busy_o), 0);
      negs(10);
      check("t5_no_done", done_cnt - d0, 0);
      p0 = pop_cnt;
      push(8'hC3, 'h386, 1'b0);
      wait_done(d0 + 1, "t5_next_done");
      check("t5_next_pops", pop_cnt - p0, 1);
      check("t5_next_len", done_cyc[d0] - pop_cyc[p0], FLEN);

`ifdef UART_TX_PARITY_EN
      // 6: even parity, 0xA5 -> parity 0, 0x07 -> parity 1
      negs(3);
      p0 = pop_cnt; d0 = done_cnt;
      push(8'hA5, 'h34A, 1'b0);
      wait_done(d0 + 1, "t6_a5_done");
      check("t6_a5_len", done_cyc[d0] - pop_cyc[p0], 44);
      negs(3);
      p0 = pop_cnt; d0 = done_cnt;
      push(8'h07, 'h20E, 1'b1);
      wait_done(d0 + 1, "t6_07_done");
      check("t6_07_len", done_cyc[d0] - pop_cyc[p0], 44);
`endif

      negs(5);
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
